// File: rtl/fb_block_writer_if.sv
// Command and dmem write-port bundle for the block framebuffer writer.
// master: command issuer / arbiter side; slave: fb_block_writer.
interface fb_block_writer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_x;
  logic [3:0]        cmd_y;
  logic [4:0]        cmd_w;
  logic [3:0]        cmd_h;
  logic [2:0]        cmd_color;
  logic              mem_gnt;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, mem_gnt,
    input  cmd_ready, mem_wren, mem_addr, mem_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, mem_gnt,
    output cmd_ready, mem_wren, mem_addr, mem_data, busy, done
  );
endinterface

// File: rtl/fb_block_writer.sv
// Rectangle-fill engine for the 20x15 block framebuffer in dmem (clipped, row-major writes).
// Optional FB_CLEAR_ON_RESET_EN: blank the whole framebuffer after every reset release.
module fb_block_writer #(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'hE00,
  parameter int unsigned       H_BLOCKS  = 20,
  parameter int unsigned       V_BLOCKS  = 15
) (
  input logic               clock,
  input logic               reset,
  fb_block_writer_if.slave  bus
);

`ifdef FB_CLEAR_ON_RESET_EN
  // StInit keeps outputs quiet for the reset cycle before the sweep starts.
  typedef enum logic [2:0] {StIdle, StWrite, StDone, StInit, StClear} state_e;
  localparam state_e ResetState = StInit;
  localparam logic [ADDR_W-1:0] LastAddr = BASE_ADDR + ADDR_W'(H_BLOCKS * V_BLOCKS - 1);
`else
  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;
  localparam state_e ResetState = StIdle;
`endif

  localparam logic [5:0] HEnd = 6'(H_BLOCKS);
  localparam logic [5:0] VEnd = 6'(V_BLOCKS);

  state_e            state_q, state_d;
  logic [5:0]        col_q, col_d, row_q, row_d;
  logic [5:0]        x0_q, x0_d, x_last_q, x_last_d, y_last_q, y_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d, step_q, step_d;
  logic [2:0]        color_q, color_d;

  logic [5:0]        x_c, y_c, xsum_c, ysum_c, xe_c, ye_c;
  logic              empty_c;
  logic [ADDR_W-1:0] start_c, step_c;

  logic              cmd_ready, mem_wren, busy, done;
  logic [31:0]       mem_data;

  assign x_c     = {1'b0, bus.cmd_x};
  assign y_c     = {2'b00, bus.cmd_y};
  assign xsum_c  = x_c + {1'b0, bus.cmd_w};
  assign ysum_c  = y_c + {2'b00, bus.cmd_h};
  assign xe_c    = (xsum_c > HEnd) ? HEnd : xsum_c;
  assign ye_c    = (ysum_c > VEnd) ? VEnd : ysum_c;
  assign empty_c = (bus.cmd_w == 5'd0) || (bus.cmd_h == 4'd0) || (x_c >= HEnd) || (y_c >= VEnd);
  // Constant multiply only feeds the accept edge, never the per-block address path.
  assign start_c = BASE_ADDR + ADDR_W'(bus.cmd_y) * ADDR_W'(H_BLOCKS) + ADDR_W'(bus.cmd_x);
  // Jump from the last column of one row to the first column of the next.
  assign step_c  = ADDR_W'(H_BLOCKS) - ADDR_W'(xe_c - x_c) + ADDR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ResetState;
      col_q    <= '0;
      row_q    <= '0;
      x0_q     <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
      addr_q   <= BASE_ADDR;
      step_q   <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x0_q     <= x0_d;
      x_last_q <= x_last_d;
      y_last_q <= y_last_d;
      addr_q   <= addr_d;
      step_q   <= step_d;
      color_q  <= color_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    x0_d      = x0_q;
    x_last_d  = x_last_q;
    y_last_d  = y_last_q;
    addr_d    = addr_q;
    step_d    = step_q;
    color_d   = color_q;
    cmd_ready = 1'b0;
    mem_wren  = 1'b0;
    mem_data  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          x0_d     = x_c;
          col_d    = x_c;
          row_d    = y_c;
          x_last_d = xe_c - 6'd1;
          y_last_d = ye_c - 6'd1;
          addr_d   = start_c;
          step_d   = step_c;
          color_d  = bus.cmd_color;
          state_d  = empty_c ? StDone : StWrite;
        end
      end
      StWrite: begin
        busy     = 1'b1;
        mem_wren = 1'b1;
        mem_data = {29'b0, color_q};
        if (bus.mem_gnt) begin
          if (col_q == x_last_q) begin
            if (row_q == y_last_q) begin
              state_d = StDone;
            end else begin
              col_d  = x0_q;
              row_d  = row_q + 6'd1;
              addr_d = addr_q + step_q;
            end
          end else begin
            col_d  = col_q + 6'd1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
`ifdef FB_CLEAR_ON_RESET_EN
      StInit: begin
        addr_d  = BASE_ADDR;
        state_d = StClear;
      end
      StClear: begin
        busy     = 1'b1;
        mem_wren = 1'b1;
        if (bus.mem_gnt) begin
          if (addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.mem_wren  = mem_wren;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = mem_data;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_fb_block_writer.sv
// Scoreboard bench for fb_block_writer: directed rectangle commands, expected dmem writes queued.
module tb_fb_block_writer;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;

`ifdef FB_CLEAR_ON_RESET_EN
  localparam logic RstReady = 1'b0;
`else
  localparam logic RstReady = 1'b1;
`endif

  fb_block_writer_if #(.ADDR_W(12)) bus ();

  fb_block_writer #(
    .ADDR_W   (12),
    .BASE_ADDR(12'hE00),
    .H_BLOCKS (20),
    .V_BLOCKS (15)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every committed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.mem_wren && bus.mem_gnt) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(bus.mem_addr), 32'(mon_e[43:32]));
        check("write_data", bus.mem_data, mon_e[31:0]);
      end
    end
  end

  task automatic push_wr(input logic [11:0] addr, input logic [2:0] color);
    exp_q.push_back({addr, 29'b0, color});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wren"}, 32'(bus.mem_wren), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'hE00);
    check({tag, "_data"}, bus.mem_data, 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'(RstReady));
  endtask

  task automatic release_reset();
`ifdef FB_CLEAR_ON_RESET_EN
    int  k;
    bit  seen;
    bit  ready_seen;
    for (int i = 0; i < 300; i++) exp_q.push_back({12'(3584 + i), 32'h0});
    rst = 1'b0;
    k = 0;
    seen = 1'b0;
    ready_seen = 1'b0;
    while (k < 400 && !seen) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.cmd_ready) ready_seen = 1'b1;
        k++;
      end
    end
    check("clear_done_seen", 32'(seen), 32'd1);
    check("clear_ready_low", 32'(ready_seen), 32'd0);
    @(negedge clk);
    check("clear_ready_after", 32'(bus.cmd_ready), 32'd1);
    check("clear_drained", 32'(exp_q.size()), 32'd0);
`else
    rst = 1'b0;
`endif
  endtask

  // Issue one command; stall bit k holds mem_gnt low in cycle k after accept.
  task automatic run_cmd(input string tag, input logic [4:0] x, input logic [3:0] y,
                         input logic [4:0] w, input logic [3:0] h, input logic [2:0] c,
                         input int exp_done, input logic [15:0] stall,
                         input logic [11:0] hold);
    int k;
    bit seen;
    bit st;
    @(posedge clk);
    #1;
    check({tag, "_ready_at_issue"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_x = x;
    bus.cmd_y = y;
    bus.cmd_w = w;
    bus.cmd_h = h;
    bus.cmd_color = c;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = 5'h1f;
    bus.cmd_y = 4'hf;
    bus.cmd_w = 5'h1f;
    bus.cmd_h = 4'hf;
    bus.cmd_color = ~c;
    k = 1;
    seen = 1'b0;
    bus.mem_gnt = !stall[1];
    while (k <= 100 && !seen) begin
      @(negedge clk);
      st = (k < 16) ? stall[k[3:0]] : 1'b0;
      if (st) begin
        check({tag, "_stall_wren"}, 32'(bus.mem_wren), 32'd1);
        check({tag, "_stall_addr"}, 32'(bus.mem_addr), 32'(hold));
      end
      if (bus.done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        k++;
        bus.mem_gnt = (k < 16) ? !stall[k[3:0]] : 1'b1;
      end
    end
    check({tag, "_done_cycle"}, seen ? 32'(k) : 32'd999, 32'(exp_done));
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    bus.mem_gnt = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_w = '0;
    bus.cmd_h = '0;
    bus.cmd_color = '0;
    bus.mem_gnt = 1'b1;
    #12;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    release_reset();

    // (2,3) 2x2: rows start at 0xE3E and 0xE52.
    push_wr(12'hE3E, 3'd5);
    push_wr(12'hE3F, 3'd5);
    push_wr(12'hE52, 3'd5);
    push_wr(12'hE53, 3'd5);
    run_cmd("basic", 5'd2, 4'd3, 5'd2, 4'd2, 3'd5, 5, 16'h0, 12'h0);

    // Bottom-right corner clip.
    push_wr(12'hF2A, 3'd3);
    push_wr(12'hF2B, 3'd3);
    run_cmd("clip", 5'd18, 4'd14, 5'd5, 4'd4, 3'd3, 3, 16'h0, 12'h0);

    // Right-edge clip with a row wrap: cols 17..19 of rows 0 and 1.
    push_wr(12'hE11, 3'd6);
    push_wr(12'hE12, 3'd6);
    push_wr(12'hE13, 3'd6);
    push_wr(12'hE25, 3'd6);
    push_wr(12'hE26, 3'd6);
    push_wr(12'hE27, 3'd6);
    run_cmd("wrap", 5'd17, 4'd0, 5'd10, 4'd2, 3'd6, 7, 16'h0, 12'h0);

    run_cmd("empty_x", 5'd20, 4'd0, 5'd4, 4'd1, 3'd2, 1, 16'h0, 12'h0);
    run_cmd("empty_w", 5'd0, 4'd0, 5'd0, 4'd5, 3'd6, 1, 16'h0, 12'h0);

    push_wr(12'hE00, 3'd7);
    push_wr(12'hE01, 3'd7);
    push_wr(12'hE02, 3'd7);
    run_cmd("stall", 5'd0, 4'd0, 5'd3, 4'd1, 3'd7, 7, 16'b0000_0000_0001_1100, 12'hE01);

    // Reset while the second block of a w=10 fill is on the bus.
    push_wr(12'hE00, 3'd4);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_x = 5'd0;
    bus.cmd_y = 4'd0;
    bus.cmd_w = 5'd10;
    bus.cmd_h = 4'd1;
    bus.cmd_color = 3'd4;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check("midrst_drained", 32'(exp_q.size()), 32'd0);
    release_reset();

    push_wr(12'hE00, 3'd1);
    run_cmd("after_rst", 5'd0, 4'd0, 5'd1, 4'd1, 3'd1, 2, 16'h0, 12'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
